seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_tx_pkg.sv | 24 ++
 rtl/seq_pattern_tx_if.sv | 30 +++
 rtl/seq_tx_shreg.sv | 29 ++
 rtl/seq_pattern_tx.sv | 175 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and default configuration for the seq_pattern_tx serializer.
// The GAP state is only part of the encoding when SEQ_TX_GAP_EN is defined.
package seq_tx_pkg;

  localparam int unsigned SEQ_TX_W       = 4;
  localparam int unsigned SEQ_TX_RPT_W   = 4;
  localparam int unsigned SEQ_TX_GAP_LEN = 2;

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle for seq_pattern_tx: master drives the request side,
// slave (the transmitter) drives the serial stream and status.
interface seq_pattern_tx_if
  import seq_tx_pkg::*;
#(
  parameter int unsigned W     = SEQ_TX_W,
  parameter int unsigned RPT_W = SEQ_TX_RPT_W
);

  logic             start;
  logic [W-1:0]     pattern;
  logic [RPT_W-1:0] reps;
  logic             abort;
  logic             dout;
  logic             dvalid;
  logic             dmark;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps, abort,
    input  dout, dvalid, dmark, busy, done
  );

  modport slave (
    input  start, pattern, reps, abort,
    output dout, dvalid, dmark, busy, done
  );

endinterface

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register; sout is the register MSB, so the
// serial output is a flop. Shifting fills with zeros.
module seq_tx_shreg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign sout = sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured W-bit pattern MSB first, reps times.
// Build option SEQ_TX_GAP_EN inserts GAP_LEN idle-valid zero bits between repetitions.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned W       = SEQ_TX_W,
  parameter int unsigned RPT_W   = SEQ_TX_RPT_W,
  parameter int unsigned GAP_LEN = SEQ_TX_GAP_LEN
) (
  input logic             clk,
  input logic             reset,
  seq_pattern_tx_if.slave tx
);

  localparam int unsigned     BW       = $clog2(W);
  localparam logic [BW-1:0]   BIT_LAST = BW'(W - 1);

  state_t           state, state_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [RPT_W-1:0] repcnt, repcnt_n;
  logic [W-1:0]     pattern_q, pattern_n;

  logic             sr_clear, sr_load, sr_shift, sr_out;
  logic [W-1:0]     sr_din;

  logic             dvalid_q, dmark_q, busy_q, done_q;
  logic             dvalid_d, dmark_d, busy_d, done_d;

`ifdef SEQ_TX_GAP_EN
  localparam int unsigned   GW       = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
  logic [GW-1:0]            gapcnt, gapcnt_n;
`else
  // GAP_LEN stays in the parameter list for instantiation compatibility only
  if (GAP_LEN == 0) begin : g_gap_unused
  end
`endif

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      repcnt    <= '0;
      pattern_q <= '0;
      dvalid_q  <= 1'b0;
      dmark_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gapcnt    <= '0;
`endif
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      repcnt    <= repcnt_n;
      pattern_q <= pattern_n;
      dvalid_q  <= dvalid_d;
      dmark_q   <= dmark_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_TX_GAP_EN
      gapcnt    <= gapcnt_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt;
    repcnt_n  = repcnt;
    pattern_n = pattern_q;
    sr_clear  = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = pattern_q;
`ifdef SEQ_TX_GAP_EN
    gapcnt_n  = gapcnt;
`endif
    case (state)
      S_IDLE: begin
        if (!tx.abort && tx.start) begin
          if (tx.reps == '0) begin
            state_n = S_DONE;
          end else begin
            state_n   = S_SHIFT;
            pattern_n = tx.pattern;
            repcnt_n  = tx.reps;
            bitcnt_n  = '0;
            sr_din    = tx.pattern;
            sr_load   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (tx.abort) begin
          state_n  = S_IDLE;
          sr_clear = 1'b1;
          bitcnt_n = '0;
          repcnt_n = '0;
        end else if (bitcnt == BIT_LAST) begin
          bitcnt_n = '0;
          if (repcnt == RPT_W'(1)) begin
            state_n  = S_DONE;
            sr_clear = 1'b1;
            repcnt_n = '0;
          end else begin
            repcnt_n = repcnt - 1'b1;
`ifdef SEQ_TX_GAP_EN
            state_n  = S_GAP;
            sr_clear = 1'b1;
            gapcnt_n = '0;
`else
            sr_load  = 1'b1;
`endif
          end
        end else begin
          sr_shift = 1'b1;
          bitcnt_n = bitcnt + 1'b1;
        end
      end
`ifdef SEQ_TX_GAP_EN
      S_GAP: begin
        if (tx.abort) begin
          state_n  = S_IDLE;
          sr_clear = 1'b1;
          repcnt_n = '0;
          gapcnt_n = '0;
        end else if (gapcnt == GAP_LAST) begin
          state_n  = S_SHIFT;
          sr_load  = 1'b1;
          bitcnt_n = '0;
          gapcnt_n = '0;
        end else begin
          gapcnt_n = gapcnt + 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n  = S_IDLE;
        sr_clear = 1'b1;
      end
    endcase
  end

  always_comb begin
    dvalid_d = (state_n == S_SHIFT);
`ifdef SEQ_TX_GAP_EN
    dvalid_d = dvalid_d || (state_n == S_GAP);
`endif
    dmark_d  = (state_n == S_SHIFT) && (bitcnt_n == BIT_LAST);
    busy_d   = (state_n != S_IDLE);
    done_d   = (state_n == S_DONE);
  end

  seq_tx_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .clear (sr_clear),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .sout  (sr_out)
  );

  assign tx.dout   = sr_out;
  assign tx.dvalid = dvalid_q;
  assign tx.dmark  = dmark_q;
  assign tx.busy   = busy_q;
  assign tx.done   = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of the expected output stream.
module tb_seq_pattern_tx;

  localparam int unsigned W       = 4;
  localparam int unsigned RPT_W   = 4;
  localparam int unsigned GAP_LEN = 2;

  typedef struct packed {
    logic dout;
    logic dvalid;
    logic dmark;
    logic busy;
    logic done;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  ent_t cur = '0;
  ent_t q[$];

  seq_pattern_tx_if #(.W(W), .RPT_W(RPT_W)) tx ();

  seq_pattern_tx #(.W(W), .RPT_W(RPT_W), .GAP_LEN(GAP_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected cycle sequence of a whole transmission, built from the stream rules
  task automatic model_build(input logic [W-1:0] pat, input int nreps);
    ent_t e;
    for (int r = 0; r < nreps; r++) begin
      for (int i = W - 1; i >= 0; i--) begin
        e = '0;
        e.dout = pat[i]; e.dvalid = 1'b1; e.dmark = (i == 0); e.busy = 1'b1;
        q.push_back(e);
      end
`ifdef SEQ_TX_GAP_EN
      if (r < nreps - 1) begin
        for (int g = 0; g < int'(GAP_LEN); g++) begin
          e = '0; e.dvalid = 1'b1; e.busy = 1'b1;
          q.push_back(e);
        end
      end
`endif
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic model_step();
    if (reset) begin
      q.delete(); cur = '0;
    end else if (cur.dvalid && tx.abort) begin
      q.delete(); cur = '0;
    end else if (cur.busy) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
    end else if (tx.start && !tx.abort) begin
      model_build(tx.pattern, int'(tx.reps));
      cur = q.pop_front();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("dout",   tx.dout,   cur.dout);
    chk("dvalid", tx.dvalid, cur.dvalid);
    chk("dmark",  tx.dmark,  cur.dmark);
    chk("busy",   tx.busy,   cur.busy);
    chk("done",   tx.done,   cur.done);
  endtask

  task automatic kick(input logic [W-1:0] pat, input logic [RPT_W-1:0] n);
    tx.pattern = pat; tx.reps = n; tx.start = 1'b1;
    tick();
    tx.start = 1'b0;
  endtask

  initial begin
    logic [15:0] stream, marks;
    int          nb, done_at, busy_cycles;
    int          s_reps, s_nb, s_done;
    logic [15:0] s_bits, s_marks;
    int          sel;

    reset = 1'b1; tx.start = 1'b0; tx.abort = 1'b0;
    tx.pattern = '0; tx.reps = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

`ifdef SEQ_TX_GAP_EN
    s_reps = 2; s_nb = 10; s_done = 11; s_bits = 16'h0249; s_marks = 16'h0041;
`else
    s_reps = 3; s_nb = 12; s_done = 13; s_bits = 16'h0999; s_marks = 16'h0111;
`endif
    // Full stream of 1001, collected and compared as a bit string
    stream = '0; marks = '0; nb = 0; done_at = 0;
    kick(4'b1001, RPT_W'(s_reps));
    for (int c = 2; c <= s_done + 2; c++) begin
      if (tx.dvalid) begin
        stream = {stream[14:0], tx.dout}; marks = {marks[14:0], tx.dmark}; nb++;
      end
      tick();
      if (tx.done && done_at == 0) done_at = c;
    end
    chk("s1_bits", stream, s_bits);
    chk("s1_marks", marks, s_marks);
    chk("s1_nbits", nb, s_nb);
    chk("s1_done_cycle", done_at, s_done);

    // reps=0: done pulse next cycle, busy for exactly one cycle
    busy_cycles = 0;
    kick(4'b1011, '0);
    chk("r0_done", tx.done, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (tx.busy) busy_cycles++;
      tick();
    end
    chk("r0_busy_cycles", busy_cycles, 1);

    // Abort while bit 6 is on dout, then a fresh start runs to completion
    kick(4'b1001, 4'd3);
    for (int c = 0; c < 5; c++) tick();
    tx.abort = 1'b1; tick(); tx.abort = 1'b0;
    chk("abort_idle", {tx.busy, tx.dvalid, tx.done}, 3'b000);
    for (int c = 0; c < 3; c++) tick();
    kick(4'b1100, 4'd1);
    for (int c = 0; c < 8; c++) tick();

    // Abort and start together in IDLE: start ignored
    tx.abort = 1'b1; kick(4'b1111, 4'd2); tx.abort = 1'b0;
    chk("abort_prio", tx.busy, 1'b0);
    tick();

    // Start with a new pattern mid-stream must not disturb it
    kick(4'b1001, 4'd2);
    tick(); tick();
    tx.pattern = 4'b0110; tx.reps = 4'd5; tx.start = 1'b1;
    tick(); tick();
    tx.start = 1'b0;
    for (int c = 0; c < 12; c++) tick();

    // Reset while bit 3 is on dout
    kick(4'b1001, 4'd3);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid", {tx.dout, tx.dvalid, tx.dmark, tx.busy, tx.done}, 5'b0);
    for (int c = 0; c < 4; c++) tick();

    // Maximum repetition count
    kick(4'b1010, 4'd15);
    for (int c = 0; c < 75; c++) tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      tx.abort = ($urandom_range(0, 39) == 0);
      tx.start = ($urandom_range(0, 3) == 0);
      tx.pattern = W'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      tx.reps = '0;
      else if (sel == 1) tx.reps = 4'd15;
      else               tx.reps = RPT_W'($urandom_range(1, 4));
      tick();
    end
    reset = 1'b0; tx.abort = 1'b0; tx.start = 1'b0;
    for (int c = 0; c < 70; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
